// File: rtl/tt_recon_pkg.sv
// Shared constants and types for the unsigned reconstructor tile.
// Holds the operand/result widths, FSM state encoding and the uio pin map,
// so the top and the shift-add core agree on bit positions.
package tt_recon_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W);

    localparam logic [7:0] UIO_OE_MASK = 8'hE0;

    localparam int START_BIT = 4;
    localparam int BUSY_BIT  = 5;
    localparam int DONE_BIT  = 6;
    localparam int ERR_BIT   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADDR = 2'd2
    } state_t;

endpackage

// File: rtl/tt_um_unsigned_reconstructor_core.sv
// recon_shift_add_core: operand registers, bit counter and accumulator of the
// sequential quotient * divisor multiply (one divisor bit per step).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture q/r/d, clear accumulator and counter
//   step       : add (q << cnt) when d[cnt] is set, advance counter
//   finish     : operation complete; re-arm the counter
//   q_in/r_in/d_in : operands from the pins
//   acc        : product accumulator
//   r_val      : captured remainder, added by the top on completion
//   last       : counter is on the final divisor bit
//   bad        : operands are not a legal divider output (only computed when
//                TT_RECON_CHECK_EN is defined, otherwise constant 0)
module recon_shift_add_core
    import tt_recon_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [OP_W-1:0]  q_in,
    input  logic [OP_W-1:0]  r_in,
    input  logic [OP_W-1:0]  d_in,
    output logic [RES_W-1:0] acc,
    output logic [OP_W-1:0]  r_val,
    output logic             last,
    output logic             bad
);

    logic [OP_W-1:0]  q_reg;
    logic [OP_W-1:0]  d_reg;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
            r_val <= '0;
            d_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            q_reg <= q_in;
            r_val <= r_in;
            d_reg <= d_in;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            if (d_reg[cnt]) begin
                acc <= acc + (RES_W'(q_reg) << cnt);
            end
            cnt <= cnt + CNT_W'(1);
        end else if (finish) begin
            cnt <= '0;
        end
    end

    assign last = (cnt == CNT_W'(OP_W - 1));

`ifdef TT_RECON_CHECK_EN
    // A real divider never emits d == 0 or r >= d.
    assign bad = (d_reg == '0) || (r_val >= d_reg);
`else
    assign bad = 1'b0;
`endif

endmodule

// File: rtl/tt_um_unsigned_reconstructor.sv
// tt_um_unsigned_reconstructor: rebuilds dividend = quotient * divisor + remainder
// from the 8-bit divider tile's outputs, using the same Tiny Tapeout pin map.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : tile enable; 0 freezes every register
//   ui_in      : {quotient[3:0], remainder[3:0]}
//   uio_in     : [3:0] divisor, [4] start (rising edge), [7:5] unused
//   uo_out     : reconstructed dividend, held until the next completion
//   uio_out    : [5] busy, [6] done (one-cycle pulse), [7] err, [4:0] 0
//   uio_oe     : constant 8'hE0
// Optional macro TT_RECON_CHECK_EN: flags err when operands are not a legal
// divider result; without it err is constant 0.
// Handshake: start is accepted only as a 0->1 pin edge while IDLE and ena=1;
// busy is high from the capture edge to the completion edge, and done pulses
// for one cycle with uo_out/err valid from that same cycle onward.
module tt_um_unsigned_reconstructor
    import tt_recon_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t state, state_nxt;

    logic             start_q;
    logic             start_edge;
    logic             load, step, finish;
    logic [RES_W-1:0] acc;
    logic [OP_W-1:0]  r_val;
    logic             last;
    logic             bad;
    logic [RES_W-1:0] uo_q;
    logic             done_q;
    logic             err_q;
    logic             busy;
    logic             unused_pins;

    assign unused_pins = &{1'b0, uio_in[7:5]};

    assign start_edge = uio_in[START_BIT] & ~start_q;

    recon_shift_add_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .finish (finish),
        .q_in   (ui_in[7:4]),
        .r_in   (ui_in[3:0]),
        .d_in   (uio_in[3:0]),
        .acc    (acc),
        .r_val  (r_val),
        .last   (last),
        .bad    (bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Core strobes are only raised when enabled, so ena=0 freezes the core too.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        load      = 1'b1;
                        state_nxt = MUL;
                    end
                end
                MUL: begin
                    step = 1'b1;
                    if (last) begin
                        state_nxt = ADDR;
                    end
                end
                ADDR: begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            uo_q    <= '0;
            err_q   <= 1'b0;
        end else if (ena) begin
            start_q <= uio_in[START_BIT];
            done_q  <= finish;
            if (finish) begin
                // Max 15*15 + 15 = 240 fits in RES_W bits; no wrap possible.
                uo_q  <= acc + RES_W'(r_val);
                err_q <= bad;
            end
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = busy;
        uio_out[DONE_BIT] = done_q;
        uio_out[ERR_BIT]  = err_q;
    end

    assign uo_out = uo_q;
    assign uio_oe = UIO_OE_MASK;

endmodule
